// File: rtl/mem_loader.sv
// mem_loader: front-panel loader that steps a RAM pointer on each debounced key
// press. In load mode it writes the switch data; in check mode it reads a word
// back into check_out.
// Optional feature: define LOADER_VERIFY_EN to follow every write with a
// read-back (VRD/VCMP) that sets the sticky err flag on a mismatch.
module mem_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpustate,
  input  logic              A1,
  input  logic [7:0]        D,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_out,
  output logic              write,
  output logic              read,
  output logic [7:0]        check_out,
  output logic              busy,
  output logic              err
);

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_CHECK = 2'b10;

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_VRD, S_VCMP, S_RD, S_LATCH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_LATCH} state_t;
`endif

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                   sync_level;
  logic [CNT_W-1:0]       deb_cnt_reg;
  logic                   deb_reg, deb_prev_reg;
  logic                   step_evt;
  logic [1:0]             mode_reg;
  logic                   mode_chg;
  logic [ADDR_W-1:0]      ptr_reg;
  logic [7:0]             data_out_reg;
  logic [7:0]             check_out_reg;
  logic                   op_done;

  // Synchronizer chain: stage 0 samples the raw key, later stages retime it.
  genvar gi;
  assign sync_next[0] = A1;
  for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_next[gi] = sync_reg[gi-1];
  end
  assign sync_level = sync_reg[SYNC_STAGES-1];

  // Synchronizer registers, cleared to key-released.
  always_ff @(posedge clk) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= sync_next;
  end

  // Debouncer: accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_cnt_reg  <= '0;
      deb_reg      <= 1'b0;
      deb_prev_reg <= 1'b0;
    end else begin
      deb_prev_reg <= deb_reg;
      if (sync_level == deb_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == CNT_LAST) begin
        deb_reg     <= sync_level;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + CNT_W'(1);
      end
    end
  end

  // One pulse per press, on the rising edge of the debounced level.
  assign step_evt = deb_reg & ~deb_prev_reg;

  // Remember last mode so any change can abort the current operation.
  always_ff @(posedge clk) begin
    mode_reg <= cpustate;
  end
  assign mode_chg = (cpustate != mode_reg);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; a mode change always wins and drops back to idle.
  always_comb begin
    state_next = state_reg;
    if (mode_chg) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (step_evt && cpustate == MODE_LOAD)       state_next = S_WR;
          else if (step_evt && cpustate == MODE_CHECK) state_next = S_RD;
        end
`ifdef LOADER_VERIFY_EN
        S_WR:    state_next = S_VRD;
        S_VRD:   state_next = S_VCMP;
        S_VCMP:  state_next = S_IDLE;
`else
        S_WR:    state_next = S_IDLE;
`endif
        S_RD:    state_next = S_LATCH;
        S_LATCH: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output decode: strobes come straight from the state, so they never overlap.
  always_comb begin
    write = 1'b0;
    read  = 1'b0;
    busy  = (state_reg != S_IDLE);
    case (state_reg)
      S_WR:    write = 1'b1;
`ifdef LOADER_VERIFY_EN
      S_VRD:   read  = 1'b1;
`endif
      S_RD:    read  = 1'b1;
      default: ;
    endcase
  end

  // The last state of each operation is where the pointer advances.
`ifdef LOADER_VERIFY_EN
  assign op_done = (state_reg == S_VCMP) || (state_reg == S_LATCH);
`else
  assign op_done = (state_reg == S_WR) || (state_reg == S_LATCH);
`endif

  // Datapath: pointer, captured switch data and checked word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg       <= '0;
      data_out_reg  <= 8'h00;
      check_out_reg <= 8'h00;
    end else if (mode_chg) begin
      ptr_reg <= '0;
    end else begin
      if (state_reg == S_IDLE && step_evt && cpustate == MODE_LOAD) data_out_reg <= D;
      if (state_reg == S_LATCH) check_out_reg <= data_in;
      if (op_done) ptr_reg <= ptr_reg + ADDR_W'(1);
    end
  end

`ifdef LOADER_VERIFY_EN
  logic err_reg;

  // Sticky mismatch flag, cleared only by reset or a mode change.
  always_ff @(posedge clk) begin
    if (!rst)                                                 err_reg <= 1'b0;
    else if (mode_chg)                                        err_reg <= 1'b0;
    else if (state_reg == S_VCMP && data_in != data_out_reg) err_reg <= 1'b1;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign addr      = ptr_reg;
  assign data_out  = data_out_reg;
  assign check_out = check_out_reg;

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a key level change.
REQ-002 SHALL have parameter ADDR_W, default 8: pointer and address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cpustate  input  2  mode: 00 halt, 01 load, 10 check, 11 run.
REQ-006 SHALL have port A1  input  1  raw step key, asynchronous, bouncing.
REQ-007 SHALL have port D  input  8  switch data to store.
REQ-008 SHALL have port data_in  input  8  RAM read data, valid the cycle after read=1.
REQ-009 SHALL have port addr  output  ADDR_W  RAM address (current pointer).
REQ-010 SHALL have port data_out  output  8  RAM write data.
REQ-011 SHALL have port write  output  1  one-cycle RAM write strobe.
REQ-012 SHALL have port read  output  1  one-cycle RAM read strobe.
REQ-013 SHALL have port check_out  output  8  last word read in check mode.
REQ-014 SHALL have port busy  output  1  high while a step operation is in flight.
REQ-015 SHALL have port err  output  1  sticky verify-mismatch flag.

Function
REQ-016 A1 SHALL pass a 2-flop synchronizer and then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-017 A step event SHALL be a single-cycle pulse on a 0->1 transition of the debounced level; holding the key SHALL produce exactly one event.
REQ-018 FSM states SHALL be IDLE, WR, VRD, VCMP, RD, LATCH; busy=1 in every state except IDLE.
REQ-019 Load mode, IDLE + event: next cycle SHALL be WR with write=1, addr=ptr, data_out=D sampled at the event cycle.
REQ-020 Check mode, IDLE + event: next cycle SHALL be RD with read=1, addr=ptr; LATCH SHALL follow and load check_out with data_in.
REQ-021 ptr SHALL increment by 1 on leaving the final state of an operation (WR, VCMP, or LATCH); it SHALL wrap from 2^ADDR_W-1 to 0.
REQ-022 Events arriving while busy=1 SHALL be dropped, not queued.
REQ-023 Any change of cpustate SHALL return the FSM to IDLE the following cycle, clear ptr to 0, and abort the in-flight operation with write and read deasserted immediately.
REQ-024 In halt and run modes, events SHALL be ignored, and write and read SHALL stay 0.
REQ-025 write and read SHALL never be high in the same cycle.
REQ-026 addr SHALL equal ptr at all times; data_out SHALL hold the last captured D.

Reset
REQ-027 While rst=0 at a clock edge: state=IDLE, ptr=0, addr=0, data_out=0, write=0, read=0, check_out=0, busy=0, err=0, and synchronizer/debouncer cleared to key-released.
REQ-028 Reset asserted mid-operation SHALL take priority over all other behaviour; no write strobe SHALL appear in the cycle following the reset edge.

Configuration
REQ-029 Macro LOADER_VERIFY_EN defined: WR SHALL be followed by VRD (read=1, same addr), then VCMP; if data_in != data_out, err SHALL be set until reset or a cpustate change.
REQ-030 Macro LOADER_VERIFY_EN undefined: VRD and VCMP SHALL NOT exist, WR SHALL return to IDLE, and err SHALL be constant 0.

Verification
REQ-031 Reset: rst=0 for 2 cycles with A1 toggling -> every output 0; first step after release writes to addr 0.
REQ-032 Load: cpustate=01, D=8'h3C, clean press -> exactly one write=1 cycle at addr=0 with data_out=3C; ptr=1 afterwards; busy is 1 for 1 cycle (3 with LOADER_VERIFY_EN).
REQ-033 Bounce: A1 toggles every cycle for 3 cycles, then held high 10 cycles (DEBOUNCE_CYCLES=4) -> exactly one write; toggling shorter than 4 cycles alone -> no write.
REQ-034 Check: memory model holds 8'hA5 at addr 0 and 8'h5A at addr 1; cpustate=10, two presses -> check_out=A5 and then 5A; ptr=2.
REQ-035 Wrap/abort: ptr preloaded to 8'hFF by 255 steps, one more load step -> write at FF, ptr=00; cpustate changes 01->10 in the WR cycle -> write drops the next cycle and ptr=0.
REQ-036 Verify (LOADER_VERIFY_EN): memory model corrupts bit 0 on write, D=8'h10 -> readback 8'h11 sets err=1; err holds through further steps and clears on a cpustate change.
